// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - two-stage valid/ready W x W multiplier with per-operation truncated-row approximation
module approx_mult_pipe #(
  parameter int W     = 8,
  parameter int K     = 2,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_x,
  input  logic [W-1:0]       in_y,
  input  logic               in_approx,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_z,
  output logic               out_approx,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int ZW = 2 * W;
  localparam logic [W-1:0] LO_MASK = W'((64'd1 << K) - 64'd1);

  logic [W-1:0]     w_x_hi;
  logic [W-1:0]     w_x_lo;
  logic [ZW-1:0]    w_hi_prod;
  logic [ZW-1:0]    w_hi_term;
  logic [ZW-1:0]    w_lo_exact;
  logic [ZW-1:0]    w_lo_approx;
  logic             w_en1;
  logic             w_en2;

  logic             r_s1_valid;
  logic [ZW-1:0]    r_s1_hi;
  logic [ZW-1:0]    r_s1_lo;
  logic             r_s1_approx;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_s2_valid;
  logic [ZW-1:0]    r_z;
  logic             r_approx;
  logic [TAG_W-1:0] r_tag;

  // Split x into kept high rows and the K low rows that approximate mode truncates.
  assign w_x_hi     = in_x >> K;
  assign w_x_lo     = in_x & LO_MASK;
  assign w_hi_prod  = ZW'(in_y) * ZW'(w_x_hi);
  assign w_hi_term  = w_hi_prod << K;
  assign w_lo_exact = ZW'(in_y) * ZW'(w_x_lo);

  // Low rows: bits at or above column W stay exact, column W-1 rounds up to weight 2^W, the rest drop.
  always_comb begin
    w_lo_approx = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < W; j++) begin
        if (i + j >= W) begin
          w_lo_approx = w_lo_approx + (ZW'(in_x[i] & in_y[j]) << (i + j));
        end else if (i + j == W - 1) begin
          w_lo_approx = w_lo_approx + (ZW'(in_x[i] & in_y[j]) << W);
        end
      end
    end
  end

  assign w_en2    = !r_s2_valid || out_ready;
  assign w_en1    = !r_s1_valid || w_en2;
  assign in_ready = w_en1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_hi     <= '0;
      r_s1_lo     <= '0;
      r_s1_approx <= 1'b0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_z         <= '0;
      r_approx    <= 1'b0;
      r_tag       <= '0;
    end else begin
      if (w_en1) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_hi     <= w_hi_term;
          r_s1_lo     <= in_approx ? w_lo_approx : w_lo_exact;
          r_s1_approx <= in_approx;
          r_s1_tag    <= in_tag;
        end
      end
      // Output registers only move when downstream can take them, so a stalled result holds.
      if (w_en2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_z      <= r_s1_hi + r_s1_lo;
          r_approx <= r_s1_approx;
          r_tag    <= r_s1_tag;
        end
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_z      = r_z;
  assign out_approx = r_approx;
  assign out_tag    = r_tag;

endmodule
